// File: rtl/photonic_tx_unit.sv
// Transmit endpoint of the photonic message protocol: holds one word, waits for the
// destination's RTR token, then serialises the word LSB-first in LINK_WIDTH-bit beats.
module photonic_tx_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LINK_WIDTH = 8,
  parameter int unsigned NODES      = 4,
  parameter int unsigned NODE_ID    = 0,
  localparam int unsigned BEATS     = WIDTH / LINK_WIDTH,
  localparam int unsigned NB        = $clog2(NODES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_request,
  input  logic [NB-1:0]         send_dest,
  input  logic [WIDTH-1:0]      send_data,
  output logic                  send_busy,
  output logic                  send_done,
  input  logic                  rtr_set,
  input  logic [NB-1:0]         rtr_src,
  output logic                  tx_valid,
  output logic [NB-1:0]         tx_dest,
  output logic [LINK_WIDTH-1:0] tx_data,
  output logic                  tx_last
);

  localparam int unsigned BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);
  localparam logic [NB-1:0] SelfId   = NB'(NODE_ID);

  typedef enum logic [1:0] {StIdle, StWaitRtr, StSend, StDone} state_e;

  state_e           state_q, state_d;
  logic [NB-1:0]    dest_q, dest_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [NODES-1:0] rtr_flags_q, rtr_flags_d;
  logic             consume;

  assign consume = (state_q == StWaitRtr) && rtr_flags_q[dest_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (send_request) state_d = (send_dest == SelfId) ? StDone : StWaitRtr;
      end
      StWaitRtr: begin
        if (consume) state_d = StSend;
      end
      StSend: begin
        if (beat_q == LastBeat) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    send_busy = (state_q != StIdle);
    send_done = (state_q == StDone);
    tx_valid  = (state_q == StSend);
    tx_dest   = '0;
    tx_data   = '0;
    tx_last   = 1'b0;
    if (state_q == StSend) begin
      tx_dest = dest_q;
      tx_data = data_q[LINK_WIDTH-1:0];
      tx_last = (beat_q == LastBeat);
    end
  end

  // Datapath: the word is shifted down each beat so the current beat is always the low slice.
  always_comb begin
    dest_d      = dest_q;
    data_d      = data_q;
    beat_d      = beat_q;
    rtr_flags_d = rtr_flags_q;
    if ((state_q == StIdle) && send_request) begin
      dest_d = send_dest;
      data_d = send_data;
    end
    if (consume) begin
      rtr_flags_d[dest_q] = 1'b0;
      beat_d              = '0;
    end
    if (state_q == StSend) begin
      data_d = data_q >> LINK_WIDTH;
      beat_d = (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
    end
    // Applied after the consume so a token arriving on the consume edge is kept.
    if (rtr_set && (rtr_src != SelfId)) rtr_flags_d[rtr_src] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q      <= '0;
      data_q      <= '0;
      beat_q      <= '0;
      rtr_flags_q <= '0;
    end else begin
      dest_q      <= dest_d;
      data_q      <= data_d;
      beat_q      <= beat_d;
      rtr_flags_q <= rtr_flags_d;
    end
  end

endmodule

// File: tb/tb_photonic_tx_unit.sv
// Directed self-checking bench for photonic_tx_unit (WIDTH=32, LINK_WIDTH=8, NODES=4, NODE_ID=0).
module tb_photonic_tx_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_request = 1'b0;
  logic [1:0]  send_dest = '0;
  logic [31:0] send_data = '0;
  logic        send_busy, send_done;
  logic        rtr_set = 1'b0;
  logic [1:0]  rtr_src = '0;
  logic        tx_valid, tx_last;
  logic [1:0]  tx_dest;
  logic [7:0]  tx_data;

  int checks = 0;
  int failures = 0;

  photonic_tx_unit #(
    .WIDTH(32), .LINK_WIDTH(8), .NODES(4), .NODE_ID(0)
  ) dut (
    .clk(clk), .reset(reset),
    .send_request(send_request), .send_dest(send_dest), .send_data(send_data),
    .send_busy(send_busy), .send_done(send_done),
    .rtr_set(rtr_set), .rtr_src(rtr_src),
    .tx_valid(tx_valid), .tx_dest(tx_dest), .tx_data(tx_data), .tx_last(tx_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({send_busy, send_done, tx_valid, tx_last, tx_dest, tx_data} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b valid=%b last=%b dest=%0d data=%h need all 0",
               send_busy, send_done, tx_valid, tx_last, tx_dest, tx_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (send_busy !== 1'b0 || tx_valid !== 1'b0 || dut.rtr_flags_q !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release got busy=%b valid=%b flags=%b need 0 0 0000",
               send_busy, tx_valid, dut.rtr_flags_q);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    rtr_set = 1'b1; rtr_src = 2'd2; tick(); rtr_set = 1'b0;
    send_request = 1'b1; send_dest = 2'd2; send_data = w; tick(); send_request = 1'b0;
    checks++;
    if (send_busy !== 1'b1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_wait got busy=%b valid=%b need 1 0", send_busy, tx_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== w[i*8 +: 8] || tx_dest !== 2'd2 ||
          tx_last !== (i == 3) || send_done !== 1'b0) begin
        failures++;
        $display("FAIL basic_beat%0d got valid=%b data=%h dest=%0d last=%b done=%b need 1 %h 2 %b 0",
                 i, tx_valid, tx_data, tx_dest, tx_last, send_done, w[i*8 +: 8], (i == 3));
      end
    end
    tick();
    checks++;
    if (send_done !== 1'b1 || tx_valid !== 1'b0 || tx_last !== 1'b0 || send_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_done got done=%b valid=%b last=%b busy=%b need 1 0 0 1",
               send_done, tx_valid, tx_last, send_busy);
    end
    tick();
    checks++;
    if (send_done !== 1'b0 || send_busy !== 1'b0 || dut.rtr_flags_q[2] !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got done=%b busy=%b flag2=%b need 0 0 0",
               send_done, send_busy, dut.rtr_flags_q[2]);
    end
  endtask

  task automatic test_wait_rtr();
    logic [31:0] w;
    w = 32'h11223344;
    send_request = 1'b1; send_dest = 2'd1; send_data = w; tick(); send_request = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (send_busy !== 1'b1 || tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL wait_stall%0d got busy=%b valid=%b need 1 0", i, send_busy, tx_valid);
      end
      tick();
    end
    rtr_set = 1'b1; rtr_src = 2'd1; tick(); rtr_set = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_token_edge got valid=%b need 0", tx_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== w[i*8 +: 8] || tx_dest !== 2'd1 || tx_last !== (i == 3)) begin
        failures++;
        $display("FAIL wait_beat%0d got valid=%b data=%h dest=%0d last=%b need 1 %h 1 %b",
                 i, tx_valid, tx_data, tx_dest, tx_last, w[i*8 +: 8], (i == 3));
      end
    end
    tick();
    checks++;
    if (send_done !== 1'b1) begin
      failures++;
      $display("FAIL wait_done got done=%b need 1", send_done);
    end
    tick();
  endtask

  task automatic test_same_edge();
    logic [31:0] w;
    w = 32'hCAFEBABE;
    rtr_set = 1'b1; rtr_src = 2'd3; tick(); rtr_set = 1'b0;
    send_request = 1'b1; send_dest = 2'd3; send_data = w; tick(); send_request = 1'b0;
    rtr_set = 1'b1; rtr_src = 2'd3; tick(); rtr_set = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hBE || dut.rtr_flags_q[3] !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_consume got valid=%b data=%h flag3=%b need 1 be 1",
               tx_valid, tx_data, dut.rtr_flags_q[3]);
    end
    for (int i = 0; i < 5; i++) tick();
    w = 32'h0F0E0D0C;
    send_request = 1'b1; send_dest = 2'd3; send_data = w; tick(); send_request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== w[i*8 +: 8] || tx_dest !== 2'd3) begin
        failures++;
        $display("FAIL same_edge_resend%0d got valid=%b data=%h dest=%0d need 1 %h 3",
                 i, tx_valid, tx_data, tx_dest, w[i*8 +: 8]);
      end
    end
    tick();
    tick();
    checks++;
    if (send_busy !== 1'b0 || dut.rtr_flags_q[3] !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_end got busy=%b flag3=%b need 0 0", send_busy, dut.rtr_flags_q[3]);
    end
  endtask

  task automatic test_ignore_busy();
    logic [31:0] w;
    int nb, nd;
    w = 32'h55667788; nb = 0; nd = 0;
    rtr_set = 1'b1; rtr_src = 2'd1; tick(); rtr_set = 1'b0;
    send_request = 1'b1; send_dest = 2'd1; send_data = w; tick(); send_request = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send_request = (i == 2);
      send_dest = 2'd0;
      tick();
      if (tx_valid === 1'b1) begin
        checks++;
        if (nb > 3 || tx_data !== w[(nb % 4)*8 +: 8] || tx_dest !== 2'd1) begin
          failures++;
          $display("FAIL busy_beat%0d got data=%h dest=%0d need %h 1",
                   nb, tx_data, tx_dest, w[(nb % 4)*8 +: 8]);
        end
        nb++;
      end
      if (send_done === 1'b1) nd++;
    end
    send_request = 1'b0;
    checks++;
    if (nb != 4 || nd != 1 || send_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore got beats=%0d dones=%0d busy=%b need 4 1 0", nb, nd, send_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    rtr_set = 1'b1; rtr_src = 2'd2; tick();
    rtr_src = 2'd1;
    send_request = 1'b1; send_dest = 2'd2; send_data = w; tick();
    send_request = 1'b0; rtr_set = 1'b0;
    tick();
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
      failures++;
      $display("FAIL rst_mid_beat1 got valid=%b data=%h need 1 be", tx_valid, tx_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || send_busy !== 1'b0 || send_done !== 1'b0 ||
        tx_data !== 8'h00 || dut.rtr_flags_q !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid_async got valid=%b last=%b busy=%b done=%b data=%h flags=%b need 0 0 0 0 00 0000",
               tx_valid, tx_last, send_busy, send_done, tx_data, dut.rtr_flags_q);
    end
    tick();
    reset = 1'b0;
    w = 32'h01020304;
    send_request = 1'b1; send_dest = 2'd1; send_data = w; tick(); send_request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b0 || send_busy !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid_flagclr%0d got valid=%b busy=%b need 0 1", i, tx_valid, send_busy);
      end
    end
    rtr_set = 1'b1; rtr_src = 2'd1; tick(); rtr_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== w[i*8 +: 8] || tx_last !== (i == 3)) begin
        failures++;
        $display("FAIL rst_mid_new%0d got valid=%b data=%h last=%b need 1 %h %b",
                 i, tx_valid, tx_data, tx_last, w[i*8 +: 8], (i == 3));
      end
    end
    tick();
    checks++;
    if (send_done !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_done got done=%b need 1", send_done);
    end
    tick();
  endtask

  task automatic test_self_send();
    rtr_set = 1'b1; rtr_src = 2'd0; tick(); rtr_set = 1'b0;
    checks++;
    if (dut.rtr_flags_q !== 4'b0000) begin
      failures++;
      $display("FAIL self_token got flags=%b need 0000", dut.rtr_flags_q);
    end
    send_request = 1'b1; send_dest = 2'd0; send_data = 32'h12345678; tick(); send_request = 1'b0;
    checks++;
    if (send_done !== 1'b1 || tx_valid !== 1'b0 || send_busy !== 1'b1) begin
      failures++;
      $display("FAIL self_done got done=%b valid=%b busy=%b need 1 0 1", send_done, tx_valid, send_busy);
    end
    tick();
    checks++;
    if (send_done !== 1'b0 || send_busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL self_idle got done=%b busy=%b valid=%b need 0 0 0", send_done, send_busy, tx_valid);
    end
    rtr_set = 1'b1; rtr_src = 2'd2; tick(); rtr_set = 1'b0;
    checks++;
    if (dut.rtr_flags_q !== 4'b0100) begin
      failures++;
      $display("FAIL self_other_token got flags=%b need 0100", dut.rtr_flags_q);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_rtr();
    test_same_edge();
    test_ignore_busy();
    test_reset_mid();
    test_self_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
